// File: rtl/epu_layer_sequencer.sv
// Layer sequencer for the EPU conv accelerator: walks a programmable descriptor
// table, driving one-hot mode/w8 and a start pulse per layer, then waits for finish.
module epu_layer_sequencer #(
  parameter int MAX_LAYERS = 16,
  parameter int TIMEOUT_W  = 20,
  localparam int LW = $clog2(MAX_LAYERS)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          cfg_we,
  input  logic [LW-1:0] cfg_addr,
  input  logic [1:0]    cfg_op,
  input  logic [31:0]   cfg_w8,
  input  logic [LW:0]   num_layers,
  input  logic          run,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic [1:0]    err,
  output logic [LW-1:0] cur_layer,
  output logic [3:0]    acc_mode,
  output logic [31:0]   acc_w8,
  output logic          acc_start,
  input  logic          acc_finish
);

  localparam int IDLE_MODE     = 0;
  localparam int CONV_3x3_MODE = 1;
  localparam int MAX_POOL_MODE = 2;
  localparam int FC_MODE       = 3;

  localparam logic [3:0]           MODE_IDLE = 4'b1 << IDLE_MODE;
  localparam logic [LW:0]          MAX_NL    = MAX_LAYERS[LW:0];
  localparam logic [TIMEOUT_W-1:0] WDOG_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT,
    S_GAP,
    S_DONE
  } state_t;

  state_t               r_state;
  state_t               w_nxt_state;
  logic [LW-1:0]        r_cur_layer;
  logic [LW-1:0]        w_nxt_layer;
  logic [LW-1:0]        r_last;
  logic [TIMEOUT_W-1:0] r_wdog;
  logic                 r_busy;
  logic                 r_done;
  logic [1:0]           r_err;
  logic [3:0]           r_acc_mode;
  logic [31:0]          r_acc_w8;
  logic                 r_acc_start;

  logic [1:0]           r_tbl_op [MAX_LAYERS];
  logic [31:0]          r_tbl_w8 [MAX_LAYERS];

  logic                 w_accept;
  logic                 w_zero_done;
  logic                 w_clr_err;
  logic [1:0]           w_set_err;
  logic [1:0]           w_cur_op;
  logic [1:0]           w_nxt_op;
  logic [31:0]          w_nxt_w8;
  logic                 w_nxt_active;
  logic                 w_nxt_unit;

  function automatic logic [3:0] op2mode(input logic [1:0] op);
    logic [3:0] m;
    m = '0;
    case (op)
      2'b01:   m[CONV_3x3_MODE] = 1'b1;
      2'b10:   m[MAX_POOL_MODE] = 1'b1;
      2'b11:   m[FC_MODE]       = 1'b1;
      default: m[IDLE_MODE]     = 1'b1;
    endcase
    return m;
  endfunction

  // Descriptor table is frozen while a sequence runs so the active layer cannot change under it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < MAX_LAYERS; i++) begin
        r_tbl_op[i] <= '0;
        r_tbl_w8[i] <= '0;
      end
    end else if (cfg_we && !r_busy) begin
      r_tbl_op[cfg_addr] <= cfg_op;
      r_tbl_w8[cfg_addr] <= cfg_w8;
    end
  end

  assign w_cur_op = r_tbl_op[r_cur_layer];
  assign w_nxt_op = r_tbl_op[w_nxt_layer];
  assign w_nxt_w8 = r_tbl_w8[w_nxt_layer];

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_layer = r_cur_layer;
    w_accept    = 1'b0;
    w_zero_done = 1'b0;
    w_clr_err   = 1'b0;
    w_set_err   = 2'b00;
    if (abort) begin
      w_nxt_state = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (run) begin
            if (num_layers > MAX_NL) begin
              w_set_err[1] = 1'b1;
            end else if (num_layers == '0) begin
              w_zero_done = 1'b1;
            end else begin
              w_accept    = 1'b1;
              w_clr_err   = 1'b1;
              w_nxt_layer = '0;
              w_nxt_state = S_LOAD;
            end
          end
        end
        S_LOAD: begin
          if (w_cur_op == 2'b00) begin
            w_set_err[1] = 1'b1;
            w_nxt_state  = S_IDLE;
          end else begin
            w_nxt_state = S_START;
          end
        end
        S_START: w_nxt_state = S_WAIT;
        S_WAIT: begin
          if (acc_finish) begin
            if (r_cur_layer == r_last) begin
              w_nxt_state = S_DONE;
            end else begin
              w_nxt_layer = r_cur_layer + 1'b1;
              w_nxt_state = S_GAP;
            end
          end else if (r_wdog == WDOG_LAST) begin
            w_set_err[0] = 1'b1;
            w_nxt_state  = S_IDLE;
          end
        end
        S_GAP:   w_nxt_state = S_LOAD;
        S_DONE:  w_nxt_state = S_IDLE;
        default: w_nxt_state = S_IDLE;
      endcase
    end
  end

  assign w_nxt_active = (w_nxt_state == S_LOAD) || (w_nxt_state == S_START) ||
                        (w_nxt_state == S_WAIT) || (w_nxt_state == S_GAP);
  assign w_nxt_unit   = (w_nxt_state == S_LOAD) || (w_nxt_state == S_START) ||
                        (w_nxt_state == S_WAIT);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= S_IDLE;
      r_cur_layer <= '0;
      r_last      <= '0;
      r_wdog      <= '0;
    end else begin
      r_state     <= w_nxt_state;
      r_cur_layer <= w_nxt_layer;
      if (w_accept) r_last <= num_layers[LW-1:0] - 1'b1;
      if (r_state == S_START) r_wdog <= '0;
      else if (r_state == S_WAIT) r_wdog <= r_wdog + 1'b1;
    end
  end

  // Outputs are registered from the next state, so mode/w8 already show the layer during LOAD.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 2'b00;
      r_acc_mode  <= MODE_IDLE;
      r_acc_w8    <= '0;
      r_acc_start <= 1'b0;
    end else begin
      r_busy      <= w_nxt_active;
      r_done      <= (w_nxt_state == S_DONE) || w_zero_done;
      r_acc_start <= (w_nxt_state == S_START);
      r_acc_mode  <= w_nxt_unit ? op2mode(w_nxt_op) : MODE_IDLE;
      if (w_nxt_state == S_LOAD) r_acc_w8 <= w_nxt_w8;
      if (w_clr_err) r_err <= 2'b00;
      else           r_err <= r_err | w_set_err;
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;
  assign cur_layer = r_cur_layer;
  assign acc_mode  = r_acc_mode;
  assign acc_w8    = r_acc_w8;
  assign acc_start = r_acc_start;

endmodule

// File: tb/tb_epu_layer_sequencer.sv
// Bench for epu_layer_sequencer: scoreboard of expected starts, a vector table of
// whole-sequence runs, and hand-written timing/abort/timeout/reset sequences.
module tb_epu_layer_sequencer;

  localparam int FIN_DLY = 5;

  logic        clk;
  logic        rstn;
  logic        cfg_we;
  logic [3:0]  cfg_addr;
  logic [1:0]  cfg_op;
  logic [31:0] cfg_w8;
  logic [4:0]  num_layers;
  logic        run;
  logic        abort;
  logic        busy;
  logic        done;
  logic [1:0]  err;
  logic [3:0]  cur_layer;
  logic [3:0]  acc_mode;
  logic [31:0] acc_w8;
  logic        acc_start;
  logic        acc_finish;

  epu_layer_sequencer #(.MAX_LAYERS(16), .TIMEOUT_W(4)) dut (
    .clk(clk), .rstn(rstn), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_op(cfg_op),
    .cfg_w8(cfg_w8), .num_layers(num_layers), .run(run), .abort(abort), .busy(busy),
    .done(done), .err(err), .cur_layer(cur_layer), .acc_mode(acc_mode), .acc_w8(acc_w8),
    .acc_start(acc_start), .acc_finish(acc_finish)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  mode;
    logic [31:0] w8;
  } exp_t;

  typedef struct {
    int          nl;
    logic [1:0]  op;
    logic [31:0] w8;
    int          exp_done;
    logic [1:0]  exp_err;
    logic        exp_busy;
    int          exp_starts;
  } vec_t;

  exp_t        sb[$];
  exp_t        e;
  vec_t        vecs[8];
  logic [1:0]  tb_op [16];
  logic [31:0] tb_w8 [16];
  int          checks = 0;
  int          errors = 0;
  int          n_start = 0;
  int          n_done = 0;
  int          fin_cnt = 0;
  logic        auto_fin = 1'b1;
  logic        prev_start = 1'b0;
  logic        prev_done = 1'b0;
  int          s0, d0;
  logic        busy_seen;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // One clock of time; also acts as the output monitor and the accelerator finish model.
  task automatic tick();
    @(negedge clk);
    acc_finish = 1'b0;
    if (!rstn) begin
      fin_cnt    = 0;
      prev_start = 1'b0;
      prev_done  = 1'b0;
    end else begin
      if (fin_cnt > 0) begin
        fin_cnt--;
        if (fin_cnt == 0) acc_finish = 1'b1;
      end
      if (acc_start) begin
        n_start++;
        chk("start_width", prev_start, 0);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL start_unexpected: start at layer %0d mode %b, none expected", cur_layer, acc_mode);
        end else begin
          e = sb.pop_front();
          chk("start_mode", acc_mode, e.mode);
          chk("start_w8", acc_w8, e.w8);
        end
        if (auto_fin) fin_cnt = FIN_DLY;
      end
      if (done) begin
        n_done++;
        chk("done_busy", busy, 0);
        chk("done_width", prev_done, 0);
      end
      prev_start = acc_start;
      prev_done  = done;
    end
  endtask

  task automatic program_entry(input int idx, input logic [1:0] op, input logic [31:0] w8, input logic upd);
    cfg_we   = 1'b1;
    cfg_addr = 4'(idx);
    cfg_op   = op;
    cfg_w8   = w8;
    tick();
    cfg_we   = 1'b0;
    if (upd) begin
      tb_op[idx] = op;
      tb_w8[idx] = w8;
    end
  endtask

  task automatic push_run(input int n);
    for (int i = 0; i < n && i < 16; i++) begin
      if (tb_op[i] == 2'b00) break;
      sb.push_back('{mode: 4'b0001 << tb_op[i], w8: tb_w8[i]});
    end
  endtask

  task automatic pulse_run(input int nl);
    num_layers = 5'(nl);
    run = 1'b1;
    tick();
    run = 1'b0;
  endtask

  task automatic wait_idle(input string nm, input int bound);
    int k;
    k = 0;
    while (busy && k < bound) begin
      tick();
      k++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: busy still %0b after %0d cycles, expected 0", nm, busy, bound);
    end
  endtask

  task automatic wait_start(input string nm, input int bound);
    int k;
    k = 0;
    do begin
      tick();
      k++;
    end while (!acc_start && k < bound);
    if (!acc_start) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: acc_start %0b after %0d cycles, expected 1", nm, acc_start, bound);
    end
  endtask

  initial begin
    rstn = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_op = '0; cfg_w8 = '0;
    num_layers = '0; run = 1'b0; abort = 1'b0; acc_finish = 1'b0;
    for (int i = 0; i < 16; i++) begin tb_op[i] = 2'b00; tb_w8[i] = '0; end

    vecs[0] = '{1,  2'b01, 32'hA5A5_A5A5, 1, 2'b00, 1'b1, 1};
    vecs[1] = '{2,  2'b10, 32'h0000_0000, 1, 2'b00, 1'b1, 2};
    vecs[2] = '{1,  2'b11, 32'hFFFF_FFFF, 1, 2'b00, 1'b1, 1};
    vecs[3] = '{1,  2'b00, 32'h0000_1234, 0, 2'b10, 1'b1, 0};
    vecs[4] = '{16, 2'b11, 32'hDEAD_BEEF, 1, 2'b00, 1'b1, 16};
    vecs[5] = '{17, 2'b01, 32'h0000_0000, 0, 2'b10, 1'b0, 0};
    vecs[6] = '{1,  2'b01, 32'h0000_0005, 1, 2'b00, 1'b1, 1};
    vecs[7] = '{0,  2'b10, 32'h0000_0007, 1, 2'b00, 1'b0, 0};

    // Reset state
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_cur_layer", cur_layer, 0);
    chk("rst_mode", acc_mode, 4'b0001);
    chk("rst_w8", acc_w8, 0);
    chk("rst_start", acc_start, 0);
    rstn = 1'b1;
    tick();

    // Three-layer sequence with modelled finish
    program_entry(0, 2'b01, 32'h11, 1'b1);
    program_entry(1, 2'b10, 32'h00, 1'b1);
    program_entry(2, 2'b11, 32'h33, 1'b1);
    auto_fin = 1'b1;
    s0 = n_start; d0 = n_done;
    push_run(3);
    pulse_run(3);
    wait_idle("t1", 200);
    repeat (2) tick();
    chk("t1_starts", n_start - s0, 3);
    chk("t1_dones", n_done - d0, 1);
    chk("t1_sb_empty", sb.size(), 0);
    chk("t1_err", err, 0);

    // Cycle-exact latency, GAP, finish during START ignored
    auto_fin = 1'b0;
    push_run(2);
    num_layers = 5'd2;
    run = 1'b1;
    tick();
    run = 1'b0;
    chk("t2_c1_start", acc_start, 0);
    chk("t2_c1_mode", acc_mode, 4'b0010);
    tick();
    chk("t2_c2_start", acc_start, 1);
    repeat (8) tick();
    chk("t2_c10_busy", busy, 1);
    acc_finish = 1'b1;
    tick();
    chk("t2_c11_mode", acc_mode, 4'b0001);
    chk("t2_c11_layer", cur_layer, 1);
    chk("t2_c11_start", acc_start, 0);
    tick();
    chk("t2_c12_mode", acc_mode, 4'b0100);
    chk("t2_c12_start", acc_start, 0);
    tick();
    chk("t2_c13_start", acc_start, 1);
    acc_finish = 1'b1;
    tick();
    chk("t2_c14_busy", busy, 1);
    chk("t2_c14_done", done, 0);
    chk("t2_c14_mode", acc_mode, 4'b0100);
    tick();
    tick();
    acc_finish = 1'b1;
    tick();
    chk("t2_c17_done", done, 1);
    chk("t2_c17_busy", busy, 0);
    chk("t2_c17_mode", acc_mode, 4'b0001);
    tick();
    chk("t2_c18_done", done, 0);

    // Abort coincident with finish in WAIT of layer 1
    program_entry(0, 2'b01, 32'h11, 1'b1);
    program_entry(1, 2'b10, 32'h22, 1'b1);
    program_entry(2, 2'b11, 32'h33, 1'b1);
    push_run(2);
    pulse_run(3);
    wait_start("t3_l0", 10);
    repeat (3) tick();
    acc_finish = 1'b1;
    wait_start("t3_l1", 10);
    repeat (2) tick();
    d0 = n_done;
    abort = 1'b1;
    acc_finish = 1'b1;
    tick();
    abort = 1'b0;
    chk("t3_busy", busy, 0);
    chk("t3_mode", acc_mode, 4'b0001);
    chk("t3_start", acc_start, 0);
    chk("t3_layer", cur_layer, 1);
    chk("t3_err", err, 0);
    repeat (20) tick();
    chk("t3_no_done", n_done - d0, 0);
    chk("t3_sb_empty", sb.size(), 0);
    chk("t3_layer_hold", cur_layer, 1);

    // Illegal op in entry 2
    program_entry(0, 2'b01, 32'hA, 1'b1);
    program_entry(1, 2'b10, 32'hB, 1'b1);
    program_entry(2, 2'b00, 32'hC, 1'b1);
    program_entry(3, 2'b11, 32'hD, 1'b1);
    auto_fin = 1'b1;
    s0 = n_start; d0 = n_done;
    push_run(4);
    pulse_run(4);
    wait_idle("t4", 200);
    chk("t4_err", err, 2'b10);
    chk("t4_starts", n_start - s0, 2);
    chk("t4_no_done", n_done - d0, 0);
    chk("t4_sb_empty", sb.size(), 0);
    chk("t4_layer", cur_layer, 2);

    // Watchdog timeout, then a valid run clears err
    program_entry(0, 2'b01, 32'h55, 1'b1);
    auto_fin = 1'b0;
    push_run(1);
    pulse_run(1);
    wait_start("t5", 10);
    repeat (15) tick();
    chk("t5_w15_busy", busy, 1);
    chk("t5_w15_err", err, 0);
    tick();
    chk("t5_to_err", err, 2'b01);
    chk("t5_to_busy", busy, 0);
    chk("t5_to_mode", acc_mode, 4'b0001);
    auto_fin = 1'b1;
    push_run(1);
    pulse_run(1);
    chk("t5_err_clr", err, 0);
    wait_idle("t5b", 100);
    chk("t5_sb_empty", sb.size(), 0);

    // Table write while busy is dropped; num_layers=0 gives a bare done
    program_entry(0, 2'b01, 32'h66, 1'b1);
    push_run(1);
    pulse_run(1);
    program_entry(0, 2'b01, 32'h77, 1'b0);
    wait_idle("t6a", 100);
    repeat (2) tick();
    push_run(1);
    pulse_run(1);
    wait_idle("t6b", 100);
    repeat (2) tick();
    chk("t6_sb_empty", sb.size(), 0);
    s0 = n_start;
    num_layers = 5'd0;
    run = 1'b1;
    tick();
    run = 1'b0;
    chk("t6_zero_done", done, 1);
    chk("t6_zero_busy", busy, 0);
    tick();
    chk("t6_zero_done_end", done, 0);
    repeat (3) tick();
    chk("t6_zero_starts", n_start - s0, 0);

    // Vector table of whole-sequence runs
    for (int v = 0; v < 8; v++) begin
      for (int i = 0; i < vecs[v].nl && i < 16; i++) program_entry(i, vecs[v].op, vecs[v].w8, 1'b1);
      s0 = n_start; d0 = n_done;
      if (vecs[v].nl >= 1 && vecs[v].nl <= 16) push_run(vecs[v].nl);
      pulse_run(vecs[v].nl);
      busy_seen = busy;
      wait_idle($sformatf("vec%0d", v), 400);
      repeat (2) tick();
      chk($sformatf("vec%0d_done", v), n_done - d0, vecs[v].exp_done);
      chk($sformatf("vec%0d_err", v), err, vecs[v].exp_err);
      chk($sformatf("vec%0d_busy", v), busy_seen, vecs[v].exp_busy);
      chk($sformatf("vec%0d_starts", v), n_start - s0, vecs[v].exp_starts);
      chk($sformatf("vec%0d_sb", v), sb.size(), 0);
    end

    // Asynchronous reset mid-sequence also clears the table
    program_entry(0, 2'b11, 32'h99, 1'b1);
    auto_fin = 1'b0;
    push_run(1);
    pulse_run(1);
    wait_start("t7", 10);
    repeat (2) tick();
    #2 rstn = 1'b0;
    #1;
    chk("t7_busy", busy, 0);
    chk("t7_mode", acc_mode, 4'b0001);
    chk("t7_w8", acc_w8, 0);
    chk("t7_layer", cur_layer, 0);
    chk("t7_start", acc_start, 0);
    tick();
    rstn = 1'b1;
    for (int i = 0; i < 16; i++) begin tb_op[i] = 2'b00; tb_w8[i] = '0; end
    tick();
    s0 = n_start;
    push_run(1);
    pulse_run(1);
    repeat (3) tick();
    chk("t7_tbl_err", err, 2'b10);
    chk("t7_tbl_starts", n_start - s0, 0);
    chk("t7_tbl_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
